// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-channel SPI master, mode 0 (CPOL=0, CPHA=0), MSB
//               first. Shifts one W_DATA-bit word out on MOSI while
//               capturing W_DATA bits from MISO. The serial clock is derived
//               from clk, with CLK_DIV clk cycles per spi_clk half-period.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   system clock, rising-edge active
//   rst         in   asynchronous, active-high reset
//   tx_data_i   in   word to transmit, sampled only on acceptance
//   tx_valid_i  in   load strobe, accepted only while idle
//   rx_data_o   out  last fully received word
//   rx_valid_o  out  one-cycle pulse when rx_data_o updates
//   miso_i      in   serial input, must already be synchronous to clk
//   spi_clk_o   out  serial clock, idles low
//   mosi_o      out  serial output
// ----------------------------------------------------------------------------
// Build option
//   SPI_MASTER_LOOPBACK_EN : when defined, the receive path samples the
//                            internal MOSI value instead of miso_i, so the
//                            received word equals the transmitted word.
// ============================================================================
module spi_master #(
  parameter int W_DATA  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_DATA-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic [W_DATA-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              miso_i,
  output logic              spi_clk_o,
  output logic              mosi_o
);

  // A one-bit divider counter is kept even for CLK_DIV = 1 so the
  // declaration never collapses to zero width.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(W_DATA);

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(W_DATA - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  // Holds only the bits not yet presented on MOSI: the MSB goes straight
  // into mosi_q on acceptance, so the shifter is one bit narrower than the
  // word and every stored bit is eventually driven out.
  logic [W_DATA-2:0]   pending_q;
  logic [W_DATA-1:0]   rx_shift_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [DIV_W-1:0]    div_cnt_q;
  logic                spi_clk_q;
  logic                mosi_q;
  logic [W_DATA-1:0]   rx_data_q;
  logic                rx_valid_q;

  logic                w_sample_bit;
  logic                w_div_last;

`ifdef SPI_MASTER_LOOPBACK_EN
  // miso_i is deliberately masked off; it stays in the expression only so
  // the port is not reported as dangling.
  assign w_sample_bit = mosi_q | (miso_i & 1'b0);
`else
  assign w_sample_bit = miso_i;
`endif

  assign w_div_last = (div_cnt_q == C_DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      spi_clk_q  <= 1'b0;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      // Completion strobe is a single-cycle pulse; only DONE raises it.
      rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          spi_clk_q <= 1'b0;
          mosi_q    <= 1'b0;
          if (tx_valid_i) begin
            pending_q <= tx_data_i[W_DATA-2:0];
            mosi_q    <= tx_data_i[W_DATA-1];
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            state_q   <= LOW;
          end
        end

        LOW: begin
          if (w_div_last) begin
            // Rising spi_clk edge: the slave samples MOSI, we sample MISO.
            div_cnt_q  <= '0;
            spi_clk_q  <= 1'b1;
            rx_shift_q <= {rx_shift_q[W_DATA-2:0], w_sample_bit};
            state_q    <= HIGH;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end

        HIGH: begin
          if (w_div_last) begin
            // Falling spi_clk edge: the only place MOSI advances mid-word.
            div_cnt_q <= '0;
            spi_clk_q <= 1'b0;
            if (bit_cnt_q == C_BIT_LAST) begin
              state_q <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              mosi_q    <= pending_q[W_DATA-2];
              pending_q <= {pending_q[W_DATA-3:0], 1'b0};
              state_q   <= LOW;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end

        DONE: begin
          rx_data_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
          mosi_q     <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_clk_o  = spi_clk_q;
  assign mosi_o     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master. Stimulus pushes the
//               expected received word and completion cycle into a
//               scoreboard queue; an independent monitor pops and compares
//               whenever rx_valid is seen. Serial waveforms are checked
//               cycle by cycle against a hand-derived mode-0 model.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : none (top-level bench)
// Build option: SPI_MASTER_LOOPBACK_EN changes the expected received word
//               for the tied-MISO cases to the transmitted word.
// ============================================================================
module tb_spi_master;

  localparam int W_DATA  = 32;
  localparam int CLK_DIV = 2;
  // Edge offset from acceptance to rx_valid: 2*W_DATA*CLK_DIV + 1.
  localparam int C_DONE_LAT = 2 * W_DATA * CLK_DIV + 1;

  logic              clk;
  logic              rst;
  logic [W_DATA-1:0] tx_data;
  logic              tx_valid;
  logic [W_DATA-1:0] rx_data;
  logic              rx_valid;
  logic              miso;
  logic              spi_clk;
  logic              mosi;

  // 0: MISO tied low, 1: MISO tied high, 2: MISO driven from MOSI
  logic [1:0]        miso_mode;

  assign miso = (miso_mode == 2'd2) ? mosi : miso_mode[0];

  spi_master #(
    .W_DATA  (W_DATA),
    .CLK_DIV (CLK_DIV)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .miso_i     (miso),
    .spi_clk_o  (spi_clk),
    .mosi_o     (mosi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W_DATA-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [W_DATA-1:0] act,
                     input logic [W_DATA-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W_DATA-1:0] exp_rx(input logic [W_DATA-1:0] word,
                                               input logic [1:0] mode);
`ifdef SPI_MASTER_LOOPBACK_EN
    return word;
`else
    if (mode == 2'd2) return word;
    else if (mode == 2'd1) return '1;
    else return '0;
`endif
  endfunction

  // Monitor: any rx_valid must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rx_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rx_data", rx_data, e.data);
        chk("rx_valid_cycle", W_DATA'(cyc), W_DATA'(e.cyc));
      end
    end
  end

  // Issue one transfer. Must be called away from a clock edge with the DUT
  // idle. Returns #1 after the edge that raises rx_valid, so a following
  // call lands on the very next edge (back-to-back case).
  task automatic send(input logic [W_DATA-1:0] word, input logic [1:0] mode,
                      input bit wave, input int inject_at);
    exp_t e;
    int   rises;
    logic prev_clk;
    logic exp_mosi;
    logic exp_sclk;
    int   k;
    miso_mode = mode;
    tx_data   = word;
    tx_valid  = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    e.data = exp_rx(word, mode);
    e.cyc  = cyc + C_DONE_LAT;
    sb_q.push_back(e);
    rises    = 0;
    prev_clk = 1'b0;
    for (int t = 0; t <= C_DONE_LAT; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (inject_at > 0 && t == inject_at) begin
        tx_data  = 32'h2222_2222;
        tx_valid = 1'b1;
      end else if (inject_at > 0 && t == inject_at + 1) begin
        tx_valid = 1'b0;
      end
      if (wave) begin
        k        = (t / 4 > 31) ? 31 : t / 4;
        exp_mosi = (t == C_DONE_LAT) ? 1'b0 : word[31 - k];
        exp_sclk = (t > 0 && t < 128 && ((t % 4) == 2 || (t % 4) == 3));
        chk($sformatf("mosi_t%0d", t), W_DATA'(mosi), W_DATA'(exp_mosi));
        chk($sformatf("spi_clk_t%0d", t), W_DATA'(spi_clk), W_DATA'(exp_sclk));
        if (spi_clk && !prev_clk) rises++;
        prev_clk = spi_clk;
      end
    end
    if (wave) chk("spi_clk_rise_count", W_DATA'(rises), W_DATA'(32));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_spi_clk"},  W_DATA'(spi_clk),  '0);
    chk({tag, "_mosi"},     W_DATA'(mosi),     '0);
    chk({tag, "_rx_data"},  rx_data,           '0);
    chk({tag, "_rx_valid"}, W_DATA'(rx_valid), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    miso_mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Loopback through the bench, tied high, tied low.
    send(32'hA5A5_1234, 2'd2, 1'b0, 0);
    send(32'h1234_5678, 2'd1, 1'b0, 0);
    send(32'hFFFF_FFFF, 2'd0, 1'b0, 0);

    // Waveform shape and mosi bit order.
    @(posedge clk); #1;
    send(32'h8000_0001, 2'd2, 1'b1, 0);

    // Mid-transfer tx_valid must be ignored.
    @(posedge clk); #1;
    send(32'h1111_1111, 2'd2, 1'b1, 40);

    // Back-to-back: second strobe on the edge right after rx_valid.
    @(posedge clk); #1;
    send(32'hDEAD_BEEF, 2'd2, 1'b0, 0);
    send(32'h0F0F_55AA, 2'd2, 1'b0, 0);

    // Reset while idle: rx_data must clear asynchronously.
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_idle");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-transfer (spi_clk high, mosi high at this point).
    @(posedge clk); #1;
    miso_mode = 2'd1;
    tx_data   = 32'hFFFF_FFFF;
    tx_valid  = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_xfer");
    @(posedge clk); #1;
    rst = 1'b0;

    // Any stray rx_valid here is flagged by the monitor.
    repeat (300) @(posedge clk);
    #1;
    chk("scoreboard_empty", W_DATA'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
